// File: rtl/run_sched_pkg.sv
// Shared types and helpers for the run-detect scheduler.
// Optional output port run_cnt is enabled by defining RUN_CNT_OUT_EN.
package run_sched_pkg;

  // The context struct is sized for the widest supported counter. Each
  // scheduler instance limits the run value to its own 2^CNT_W-1 ceiling.
  localparam int CNT_W_MAX = 16;
  localparam int CNT_W_DEF = 4;

  typedef logic [CNT_W_MAX-1:0] run_t;

  // Saturation ceiling for the default counter width.
  localparam run_t RUN_MAX = run_t'((1 << CNT_W_DEF) - 1);

  // Saved per-channel history: seen=0 means EMPTY, otherwise RUN(run).
  typedef struct packed {
    logic seen;
    logic last;
    run_t run;
  } ctx_t;

  // Increment that sticks at lim instead of wrapping.
  function automatic run_t sat_inc(input run_t v, input run_t lim);
    return (v >= lim) ? lim : run_t'(v + 1'b1);
  endfunction

endpackage

// File: rtl/run_detect_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, with wrap.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  logic          found;
  logic [IW-1:0] pos;

  // (ptr + i) mod N without a divider.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int i);
    int s;
    s = int'(p) + i;
    if (s >= N) s = s - N;
    return IW'(s);
  endfunction

  // Scan channels from ptr upward and grant the first one requesting.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a value unassigned, which would otherwise infer a latch.
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int i = 0; i < N; i++) begin
      pos = wrap_add(ptr, i);
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/run_detect_scheduler.sv
// Shared consecutive-equal-bit run detector, time-multiplexed over NCH
// serial requesters by a round-robin arbiter. Result is registered, 1-cycle
// latency. Define RUN_CNT_OUT_EN to add the run_cnt output port.
module run_detect_scheduler
  import run_sched_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int CNT_W = 4,
  parameter int X_TH  = 2,
  parameter int Y_TH  = 3
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic [NCH-1:0]         req,
  input  logic [NCH-1:0]         din,
  input  logic [NCH-1:0]         clr,
  output logic [NCH-1:0]         gnt,
  output logic                   out_valid,
  output logic [$clog2(NCH)-1:0] out_ch,
  output logic                   doutx,
  output logic                   douty
`ifdef RUN_CNT_OUT_EN
  ,
  output logic [CNT_W-1:0]       run_cnt
`endif
);

  localparam int   IW      = $clog2(NCH);
  localparam run_t RUN_LIM = run_t'((1 << CNT_W) - 1);
  localparam run_t X_LIM   = run_t'(X_TH);
  localparam run_t Y_LIM   = run_t'(Y_TH);

  logic [IW-1:0]  ptr;
  logic [NCH-1:0] arb_gnt;
  logic [IW-1:0]  arb_idx;
  logic           xfer;
  ctx_t           ctx [NCH];
  ctx_t           base_ctx;
  ctx_t           next_ctx;

  rr_arbiter #(.N(NCH)) u_arb (
    .req (req),
    .ptr (ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // No grant is offered while the block is held in reset.
  assign gnt  = resetn ? arb_gnt : '0;
  assign xfer = |gnt;

  // Round-robin pointer moves just past the channel that was served.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ptr <= '0;
    end else if (xfer) begin
      ptr <= (arb_idx == IW'(NCH - 1)) ? '0 : arb_idx + 1'b1;
    end
  end

  // New context for the granted channel; a same-cycle clear wins over history.
  always_comb begin
    // NOTE: combinational logic uses blocking assignments so later statements
    // see the values computed just above them.
    base_ctx = clr[arb_idx] ? '0 : ctx[arb_idx];
    next_ctx = base_ctx;
    if (!base_ctx.seen || (din[arb_idx] != base_ctx.last)) begin
      next_ctx.seen = 1'b1;
      next_ctx.last = din[arb_idx];
      next_ctx.run  = run_t'(1);
    end else begin
      next_ctx.run  = sat_inc(base_ctx.run, RUN_LIM);
    end
  end

  // Context array: granted channel takes next_ctx, others change only on clr.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: the context array is a handful of flops, not a RAM, so it is
      // reset explicitly to drop all history.
      for (int c = 0; c < NCH; c++) ctx[c] <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        if (xfer && (arb_idx == IW'(c))) begin
          ctx[c] <= next_ctx;
        end else if (clr[c]) begin
          ctx[c] <= '0;
        end
      end
    end
  end

  // Result register: flags are qualified by the transfer, out_ch holds when idle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
      doutx     <= 1'b0;
      douty     <= 1'b0;
    end else begin
      out_valid <= xfer;
      doutx     <= xfer && (next_ctx.run >= X_LIM);
      douty     <= xfer && (next_ctx.run >= Y_LIM);
      if (xfer) out_ch <= arb_idx;
    end
  end

`ifdef RUN_CNT_OUT_EN
  // Optional run length of the reported transfer, zero when no result.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      run_cnt <= '0;
    end else begin
      run_cnt <= xfer ? next_ctx.run[CNT_W-1:0] : '0;
    end
  end
`endif

endmodule

// File: tb/tb_run_detect_scheduler.sv
// Directed bench for run_detect_scheduler: u0 uses CNT_W=4, u1 uses CNT_W=2
// for saturation. Both share stimulus. Handles RUN_CNT_OUT_EN builds.
module tb_run_detect_scheduler;

  logic       clk = 1'b0;
  logic       resetn;
  logic [3:0] req, din, clr;

  logic [3:0] gnt0, gnt1;
  logic       ov0, ov1, dx0, dx1, dy0, dy1;
  logic [1:0] ch0, ch1;
`ifdef RUN_CNT_OUT_EN
  logic [3:0] rc0;
  logic [1:0] rc1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  run_detect_scheduler #(.NCH(4), .CNT_W(4), .X_TH(2), .Y_TH(3)) u0 (
    .clk(clk), .resetn(resetn), .req(req), .din(din), .clr(clr),
    .gnt(gnt0), .out_valid(ov0), .out_ch(ch0), .doutx(dx0), .douty(dy0)
`ifdef RUN_CNT_OUT_EN
    , .run_cnt(rc0)
`endif
  );

  run_detect_scheduler #(.NCH(4), .CNT_W(2), .X_TH(2), .Y_TH(3)) u1 (
    .clk(clk), .resetn(resetn), .req(req), .din(din), .clr(clr),
    .gnt(gnt1), .out_valid(ov1), .out_ch(ch1), .doutx(dx1), .douty(dy1)
`ifdef RUN_CNT_OUT_EN
    , .run_cnt(rc1)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs, check the combinational grant, then clock one transfer.
  task automatic step(input string tag, input logic [3:0] r, input logic [3:0] d,
                      input logic [3:0] c, input logic [3:0] exp_gnt);
    req = r; din = d; clr = c;
    #1;
    check({tag, ".gnt"}, 32'(gnt0), 32'(exp_gnt));
    @(posedge clk);
    #1;
  endtask

  // Registered result of u0 after the last edge.
  task automatic res(input string tag, input logic v, input logic [1:0] ch,
                     input logic x, input logic y);
    check({tag, ".valid"}, 32'(ov0), 32'(v));
    check({tag, ".ch"},    32'(ch0), 32'(ch));
    check({tag, ".x"},     32'(dx0), 32'(x));
    check({tag, ".y"},     32'(dy0), 32'(y));
  endtask

  // Registered result of the CNT_W=2 instance.
  task automatic res1(input string tag, input logic v, input logic x, input logic y);
    check({tag, ".u1valid"}, 32'(ov1), 32'(v));
    check({tag, ".u1x"},     32'(dx1), 32'(x));
    check({tag, ".u1y"},     32'(dy1), 32'(y));
  endtask

  task automatic do_reset(input string tag);
    resetn = 1'b0; req = 4'b1111; din = 4'b1111; clr = 4'b0000;
    #1;
    check({tag, ".gnt_in_reset"}, 32'(gnt0), 32'h0);
    check({tag, ".gnt1_in_reset"}, 32'(gnt1), 32'h0);
    @(posedge clk); #1;
    res({tag, ".rst"}, 1'b0, 2'd0, 1'b0, 1'b0);
    res1({tag, ".rst"}, 1'b0, 1'b0, 1'b0);
`ifdef RUN_CNT_OUT_EN
    check({tag, ".rc_rst"}, 32'(rc0), 32'h0);
`endif
    resetn = 1'b1; req = 4'b0000;
  endtask

  initial begin
    logic [1:0] ch;
    logic [3:0] d3;
    logic [3:0] ch3_bits;

    // Reset state
    resetn = 1'b0; req = '0; din = '0; clr = '0;
    @(posedge clk); #1;
    do_reset("reset");

    // 1. Run thresholds on ch0: run 1..4
    step("t1a", 4'b0001, 4'b0001, 4'b0000, 4'b0001); res("t1a", 1, 0, 0, 0);
    step("t1b", 4'b0001, 4'b0001, 4'b0000, 4'b0001); res("t1b", 1, 0, 1, 0);
    step("t1c", 4'b0001, 4'b0001, 4'b0000, 4'b0001); res("t1c", 1, 0, 1, 1);
    step("t1d", 4'b0001, 4'b0001, 4'b0000, 4'b0001); res("t1d", 1, 0, 1, 1);
`ifdef RUN_CNT_OUT_EN
    check("t1d.run_cnt", 32'(rc0), 32'd4);
`endif
    // Idle cycle: flags low, out_ch holds
    step("idle", 4'b0000, 4'b0000, 4'b0000, 4'b0000); res("idle", 0, 0, 0, 0);

    // 2. Run break after clearing ch0: 1,1,0
    step("t2clr", 4'b0000, 4'b0000, 4'b0001, 4'b0000); res("t2clr", 0, 0, 0, 0);
    step("t2a", 4'b0001, 4'b0001, 4'b0000, 4'b0001); res("t2a", 1, 0, 0, 0);
    step("t2b", 4'b0001, 4'b0001, 4'b0000, 4'b0001); res("t2b", 1, 0, 1, 0);
    step("t2c", 4'b0001, 4'b0000, 4'b0000, 4'b0001); res("t2c", 1, 0, 0, 0);

    // 3. Fairness and wrap: all request, ch2 sends 0s, others 1s
    do_reset("t3");
    for (int k = 0; k < 12; k++) begin
      ch = 2'(k % 4);
      step("t3", 4'b1111, 4'b1011, 4'b0000, 4'b0001 << ch);
      res("t3", 1, ch, (k / 4) >= 1, (k / 4) >= 2);
    end

    // 4. Interleaved ch1 (1,1,1) and ch3 (0,1,0), both holding req
    step("t4clr", 4'b0000, 4'b0000, 4'b1010, 4'b0000);
    ch3_bits = 4'b0010;  // ch3 bit sequence 0,1,0 in bits [0],[1],[2]
    for (int k = 0; k < 6; k++) begin
      d3 = {ch3_bits[k / 2], 3'b010};
      if ((k % 2) == 0) begin
        step("t4", 4'b1010, d3, 4'b0000, 4'b0010);
        res("t4.ch1", 1, 2'd1, k >= 2, k >= 4);
      end else begin
        step("t4", 4'b1010, d3, 4'b0000, 4'b1000);
        res("t4.ch3", 1, 2'd3, 0, 0);
      end
    end

    // 5. Clear collision on ch0 after building run=3; clr on idle ch1 too
    step("t5clr", 4'b0000, 4'b0000, 4'b0001, 4'b0000);
    step("t5a", 4'b0001, 4'b0001, 4'b0000, 4'b0001); res("t5a", 1, 0, 0, 0);
    step("t5b", 4'b0001, 4'b0001, 4'b0000, 4'b0001); res("t5b", 1, 0, 1, 0);
    step("t5c", 4'b0001, 4'b0001, 4'b0000, 4'b0001); res("t5c", 1, 0, 1, 1);
    step("t5col", 4'b0001, 4'b0001, 4'b0011, 4'b0001); res("t5col", 1, 0, 0, 0);
    step("t5d", 4'b0001, 4'b0001, 4'b0000, 4'b0001); res("t5d", 1, 0, 1, 0);
    // ch1 had run=3 before its clear, so it restarts at 1
    step("t5ch1", 4'b0010, 4'b0010, 4'b0000, 4'b0010); res("t5ch1", 1, 1, 0, 0);
    // ch3 untouched by clears: last=0 run=1 -> run=2
    step("t5ch3", 4'b1000, 4'b0000, 4'b0000, 4'b1000); res("t5ch3", 1, 3, 1, 0);

    // 6. Saturation on CNT_W=2 instance, then reset mid-stream
    do_reset("t6");
    for (int k = 0; k < 6; k++) begin
      step("t6", 4'b0001, 4'b0001, 4'b0000, 4'b0001);
      res1("t6", 1, k >= 1, k >= 2);
      res("t6", 1, 0, k >= 1, k >= 2);
    end
`ifdef RUN_CNT_OUT_EN
    check("t6.rc_sat", 32'(rc1), 32'd3);
`endif
    do_reset("t6mid");
    step("t6e", 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    res1("t6e", 1, 0, 0); res("t6e", 1, 0, 0, 0);
    step("t6f", 4'b0001, 4'b0001, 4'b0000, 4'b0001);
    res1("t6f", 1, 1, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/run_detect_scheduler.md
Name: run_detect_scheduler

Overview:
- Shares one consecutive-equal-bit run detector among NCH serial bit requesters.
- A round-robin arbiter grants one requester per cycle. The granted bit updates that channel's saved context (last bit, run length).
- A registered result reports whether the channel's current run of equal bits has reached the X or Y threshold.
- Sits between the serial-bit sources and downstream pattern-flag consumers. Replaces per-channel copies of the detector FSM.

Parameters:
- NCH, 4: number of requesting channels (>=2).
- CNT_W, 4: width of the per-channel saturating run counter.
- X_TH, 2: run length at or above which doutx asserts.
- Y_TH, 3: run length at or above which douty asserts. Requires 1 <= X_TH <= Y_TH <= 2^CNT_W-1.

Ports:
- clk, input, 1: clock.
- resetn, input, 1: reset, synchronous, active-low.
- req, input, NCH: per-channel request. Held high until granted.
- din, input, NCH: per-channel data bit. Sampled on grant.
- clr, input, NCH: per-channel context clear pulse.
- gnt, output, NCH: one-hot grant, combinational from req and the pointer.
- out_valid, output, 1: result valid, registered.
- out_ch, output, $clog2(NCH): channel the result belongs to.
- doutx, output, 1: run length >= X_TH.
- douty, output, 1: run length >= Y_TH.

Behaviour:
- Reset (resetn low at posedge clk):
  - Round-robin pointer = 0.
  - All contexts cleared: seen=0, last=0, run=0.
  - out_valid = 0, out_ch = 0, doutx = 0, douty = 0.
  - gnt = 0 while resetn is low.
  - Reset mid-run discards all history. The first granted bit after reset is run=1.
- Arbitration:
  - gnt selects the first channel with req=1, searching upward from the pointer with wrap-around (NCH-1 -> 0).
  - At most one bit of gnt is set. gnt = 0 when req = 0.
  - A transfer occurs when req[c] & gnt[c]. The pointer then becomes (c+1) mod NCH.
  - The pointer holds when there is no grant.
  - A requester must keep req and din stable until granted.
- Per-channel context state (seen, last, run). Effective states are EMPTY (seen=0) and RUN(n), n = 1..2^CNT_W-1. On a transfer for channel c:
  - EMPTY: run = 1, seen = 1, last = din[c].
  - RUN(n), din[c] == last: run = min(n+1, 2^CNT_W-1), saturating with no wrap.
  - RUN(n), din[c] != last: run = 1, last = din[c].
- Result timing: latency 1 cycle. The cycle after a transfer:
  - out_valid = 1, out_ch = c.
  - doutx = (new run >= X_TH).
  - douty = (new run >= Y_TH).
- No transfer: out_valid = 0, doutx = 0, douty = 0, out_ch holds its last value.
- clr[c] sets channel c to EMPTY at the clock edge.
  - clr[c] and a transfer on c in the same cycle: the clear applies first, then the bit is treated as the first bit (run = 1).
  - clr on a non-granted channel does not affect the current transfer.
- Contexts of non-granted channels never change except by clr.
- No backpressure. The downstream consumer must accept a result every cycle.

Optional Feature:
- Macro RUN_CNT_OUT_EN.
- Defined: adds output port run_cnt (CNT_W bits). It is registered alongside the result and equals the new run value of the transfer. It is 0 when out_valid = 0 and 0 on reset.
- Undefined: port absent. Counters are still CNT_W wide internally.

Decomposition:
- Package run_sched_pkg holds:
  - typedef ctx_t struct {seen, last, run[CNT_W-1:0]}.
  - Constant RUN_MAX = 2^CNT_W-1.
  - Function sat_inc.
- Sub-module rr_arbiter (parameter N): inputs req and pointer, outputs one-hot gnt and encoded index. Pure combinational; the pointer register stays in the top level.
- Context array, update logic and result register stay in run_detect_scheduler.

Test Plan:
1. Run thresholds: NCH=4, only ch0 requests, din 1,1,1,1 → results run=1,2,3,4. doutx = 0,1,1,1; douty = 0,0,1,1. out_ch = 0, out_valid = 1 each cycle after the grant.
2. Run break: ch0 din 1,1,0 → third result has doutx = 0 and douty = 0 (run = 1).
3. Fairness and wrap-around: req = 4'b1111 held → gnt sequence 0001, 0010, 0100, 1000, 0001. Pointer wraps. Each channel's context is independent: ch2 din all 0 gives douty on its third grant.
4. Interleaved context: ch1 and ch3 alternate with ch1 = 1,1,1 and ch3 = 0,1,0 → ch1 douty on its third result; ch3 never flags.
5. Clear collision: ch0 at run = 3, then clr[0] in the same cycle as a ch0 transfer with din = 1 → result run = 1, doutx = 0. Next din = 1 → doutx = 1.
6. Saturation and reset: CNT_W = 2, 6 equal bits → run saturates at 3, douty stays 1. Then resetn = 0 for one cycle mid-stream → outputs 0 and the next bit gives run = 1.
